multichannel_symmetrical_pwm: RTL and testbench

Parametrised successor to the single-channel symmetrical PWM. It drives CHANNELS complementary high/low output pairs from the shared triangular carrier produced by the local counter, with these additions:
- per-channel shadow duty registers, loaded only at the period boundary;
- per-channel override;
- a sticky trip latch;
- dead-time insertion between the high and low outputs.

It sits between the control-loop registers and the gate-driver pins, in the same clock domain as the local counter.

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/pwm_deadtime_channel.sv | 123 ++++++++++++
 rtl/multichannel_symmetrical_pwm.sv | 140 ++++++++++++++
 tb/tb_multichannel_symmetrical_pwm.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the multichannel symmetrical PWM:
//   - per-channel override codes (2 bits per channel on override_i)
//   - dead-time FSM state encoding
//   - helper deciding whether an override code forces the pair low
package pwm_pkg;

  localparam logic [1:0] OVR_NONE = 2'b00;
  localparam logic [1:0] OVR_LOW  = 2'b01;
  localparam logic [1:0] OVR_HIGH = 2'b10;
  localparam logic [1:0] OVR_RSVD = 2'b11;

  typedef enum logic [1:0] {
    DT_LOW  = 2'd0,
    DT_RISE = 2'd1,
    DT_HIGH = 2'd2,
    DT_FALL = 2'd3
  } dt_state_e;

  // The reserved code behaves like a forced-low request.
  function automatic logic ovr_forces_low(input logic [1:0] code);
    return (code == OVR_LOW) || (code == OVR_RSVD);
  endfunction

endpackage

// File: rtl/pwm_deadtime_channel.sv
// pwm_deadtime_channel
// One complementary output pair with dead-time insertion. Only built when
// PWM_DEADTIME_EN is defined.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ref_in        gated-independent reference (1 = high side wanted)
//   gate          forces the pair off and the FSM back to LOW
//   deadtime      dead-time length in clock cycles, captured on each transition
//   hi, lo        registered high/low side outputs
`ifdef PWM_DEADTIME_EN
module pwm_deadtime_channel
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ref_in,
  input  logic                gate,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                hi,
  output logic                lo
);

  localparam logic [DT_WIDTH-1:0] DT_ZERO = {DT_WIDTH{1'b0}};
  localparam logic [DT_WIDTH-1:0] DT_ONE  = DT_WIDTH'(1'b1);

  dt_state_e           state;
  dt_state_e           state_next;
  logic [DT_WIDTH-1:0] cnt;
  logic [DT_WIDTH-1:0] cnt_next;
  logic                hi_next;
  logic                lo_next;

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DT_LOW;
      cnt   <= DT_ZERO;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

  // Next-state: a reference reversal inside a dead band returns to the side
  // that was on, without a second dead band.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (gate) begin
      state_next = DT_LOW;
      cnt_next   = DT_ZERO;
    end else begin
      case (state)
        DT_LOW: begin
          if (ref_in) begin
            state_next = DT_RISE;
            cnt_next   = deadtime;
          end else begin
            state_next = DT_LOW;
          end
        end
        DT_RISE: begin
          if (!ref_in) begin
            state_next = DT_LOW;
          end else if (cnt == DT_ZERO) begin
            state_next = DT_HIGH;
          end else begin
            cnt_next = cnt - DT_ONE;
          end
        end
        DT_HIGH: begin
          if (!ref_in) begin
            state_next = DT_FALL;
            cnt_next   = deadtime;
          end else begin
            state_next = DT_HIGH;
          end
        end
        DT_FALL: begin
          if (ref_in) begin
            state_next = DT_HIGH;
          end else if (cnt == DT_ZERO) begin
            state_next = DT_LOW;
          end else begin
            cnt_next = cnt - DT_ONE;
          end
        end
        default: begin
          state_next = DT_LOW;
          cnt_next   = DT_ZERO;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    hi_next = 1'b0;
    lo_next = 1'b0;
    if (gate) begin
      hi_next = 1'b0;
      lo_next = 1'b0;
    end else begin
      case (state_next)
        DT_LOW:  lo_next = 1'b1;
        DT_HIGH: hi_next = 1'b1;
        default: begin
          hi_next = 1'b0;
          lo_next = 1'b0;
        end
      endcase
    end
  end

endmodule
`endif

// File: rtl/multichannel_symmetrical_pwm.sv
// multichannel_symmetrical_pwm
// CHANNELS complementary PWM pairs compared against a shared triangular
// carrier, with boundary-loaded shadow duties, per-channel override, a sticky
// trip latch and optional dead-time insertion.
// Build option: define PWM_DEADTIME_EN to insert the dead-time FSM per
// channel; otherwise hi = ref and lo = ~ref (registered, same latency).
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   local_counter_i      carrier count 0..current_period_i within each half
//   current_period_i     period of the running half
//   sync_phase_i         0 = rising half, 1 = falling half
//   duty_i               packed duties, channel n at [n*WIDTH +: WIDTH]
//   override_i           2-bit code per channel (none / force low / force high)
//   enable_i             global enable, sampled at the period boundary
//   trip_i, trip_clear_i fault input and latch clear
//   deadtime_i           dead-time in clock cycles
//   PWM_hi_o, PWM_lo_o   registered high/low side outputs
//   tripped_o            trip latch state
module multichannel_symmetrical_pwm
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 16,
  parameter int DT_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [WIDTH-1:0]          local_counter_i,
  input  logic [WIDTH-1:0]          current_period_i,
  input  logic                      sync_phase_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic [2*CHANNELS-1:0]     override_i,
  input  logic                      enable_i,
  input  logic                      trip_i,
  input  logic                      trip_clear_i,
  input  logic [DT_WIDTH-1:0]       deadtime_i,
  output logic [CHANNELS-1:0]       PWM_hi_o,
  output logic [CHANNELS-1:0]       PWM_lo_o,
  output logic                      tripped_o
);

  logic [WIDTH-1:0]               carrier;
  logic                           bnd;
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_duty;
  logic [CHANNELS-1:0]            ref_r;
  logic [CHANNELS-1:0]            ref_eff;
  logic [CHANNELS-1:0]            gate;
  logic                           enable_r;
  logic                           tripped_r;

  // Fold the half-period flag into one symmetric carrier value.
  always_comb begin
    if (sync_phase_i) begin
      carrier = current_period_i - local_counter_i;
    end else begin
      carrier = local_counter_i;
    end
  end

  assign bnd = sync_phase_i & (local_counter_i == current_period_i);

  // Registered compare against the shadow duty; shadows reload only at bnd.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_duty <= '0;
      ref_r       <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        ref_r[n] <= (carrier < shadow_duty[n]);
        if (bnd) begin
          shadow_duty[n] <= duty_i[n*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Sticky trip latch (set beats clear). While tripped the enable is dropped
  // so that clearing the trip only re-arms the outputs at the next boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tripped_r <= 1'b0;
      enable_r  <= 1'b0;
    end else begin
      if (trip_i) begin
        tripped_r <= 1'b1;
      end else if (trip_clear_i) begin
        tripped_r <= 1'b0;
      end
      if (trip_i || tripped_r) begin
        enable_r <= 1'b0;
      end else if (bnd) begin
        enable_r <= enable_i;
      end
    end
  end

  // Per-channel gating and override-forced reference. trip_i is used directly
  // so a fault clears the outputs on the very next edge.
  always_comb begin
    gate    = '0;
    ref_eff = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      gate[n]    = tripped_r | trip_i | ~enable_r | ovr_forces_low(override_i[2*n +: 2]);
      ref_eff[n] = ref_r[n] | (override_i[2*n +: 2] == OVR_HIGH);
    end
  end

`ifdef PWM_DEADTIME_EN
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    pwm_deadtime_channel #(
      .DT_WIDTH(DT_WIDTH)
    ) u_dt (
      .clk      (clk_i),
      .rst      (rst_i),
      .ref_in   (ref_eff[n]),
      .gate     (gate[n]),
      .deadtime (deadtime_i),
      .hi       (PWM_hi_o[n]),
      .lo       (PWM_lo_o[n])
    );
  end
`else
  logic unused_deadtime;
  assign unused_deadtime = ^deadtime_i;

  // Without dead-time the pair is the gated reference and its complement.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      PWM_hi_o <= '0;
      PWM_lo_o <= '0;
    end else begin
      PWM_hi_o <= ref_eff & ~gate;
      PWM_lo_o <= ~ref_eff & ~gate;
    end
  end
`endif

  assign tripped_o = tripped_r;

endmodule

// File: tb/tb_multichannel_symmetrical_pwm.sv
module tb_multichannel_symmetrical_pwm;
  localparam int CH = 3;
  localparam int W  = 16;
  localparam int DW = 8;
`ifdef PWM_DEADTIME_EN
  localparam int DT_ON = 1;
`else
  localparam int DT_ON = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      local_counter_i, current_period_i;
  logic              sync_phase_i;
  logic [CH*W-1:0]   duty_i;
  logic [2*CH-1:0]   override_i;
  logic              enable_i, trip_i, trip_clear_i;
  logic [DW-1:0]     deadtime_i;
  logic [CH-1:0]     PWM_hi_o, PWM_lo_o;
  logic              tripped_o;

  always #5 clk = ~clk;

  multichannel_symmetrical_pwm #(.CHANNELS(CH), .WIDTH(W), .DT_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .local_counter_i(local_counter_i),
    .current_period_i(current_period_i), .sync_phase_i(sync_phase_i),
    .duty_i(duty_i), .override_i(override_i), .enable_i(enable_i),
    .trip_i(trip_i), .trip_clear_i(trip_clear_i), .deadtime_i(deadtime_i),
    .PWM_hi_o(PWM_hi_o), .PWM_lo_o(PWM_lo_o), .tripped_o(tripped_o));

  // behavioural model state
  int            m_shadow[CH];
  bit            m_raw[CH];     // carrier<duty result seen one edge ago
  bit            m_side[CH];    // side currently owning the pair (1 = high)
  int            m_run[CH];     // consecutive evaluations wanting the other side
  int            m_thr[CH];
  bit            m_en, m_trip;
  logic [CH-1:0] exp_hi, exp_lo;
  logic          exp_trip;
  bit            chk_en = 1'b0;
  int            n_checks = 0, n_pass = 0;

  // carrier generator state
  logic [W-1:0]  cnt, cur_p, next_p;
  logic          phase;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_shadow[i] = 0; m_raw[i] = 1'b0; m_side[i] = 1'b0; m_run[i] = 0; m_thr[i] = 0;
    end
    m_en = 1'b0; m_trip = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_trip = 1'b0;
  endtask

  // One clock edge of the specification's rules, using the inputs sampled at it.
  task automatic model_update();
    int c;
    bit gated, r, bnd;
    logic [1:0] ov;
    c   = sync_phase_i ? int'(current_period_i) - int'(local_counter_i) : int'(local_counter_i);
    bnd = sync_phase_i && (local_counter_i == current_period_i);
    for (int i = 0; i < CH; i++) begin
      ov    = override_i[2*i +: 2];
      gated = m_trip || trip_i || !m_en || ov == 2'b01 || ov == 2'b11;
      r     = m_raw[i] || ov == 2'b10;
`ifdef PWM_DEADTIME_EN
      if (gated) begin
        m_side[i] = 1'b0; m_run[i] = 0; exp_hi[i] = 1'b0; exp_lo[i] = 1'b0;
      end else if (r == m_side[i]) begin
        m_run[i] = 0; exp_hi[i] = r; exp_lo[i] = !r;
      end else begin
        if (m_run[i] == 0) m_thr[i] = int'(deadtime_i) + 2;
        m_run[i]++;
        if (m_run[i] >= m_thr[i]) begin
          m_side[i] = r; m_run[i] = 0; exp_hi[i] = r; exp_lo[i] = !r;
        end else begin
          exp_hi[i] = 1'b0; exp_lo[i] = 1'b0;
        end
      end
`else
      exp_hi[i] = r && !gated;
      exp_lo[i] = !r && !gated;
`endif
      m_raw[i] = (c < m_shadow[i]);
      if (bnd) m_shadow[i] = int'(duty_i[i*W +: W]);
    end
    if (m_trip || trip_i) m_en = 1'b0;
    else if (bnd) m_en = enable_i;
    if (trip_i) m_trip = 1'b1;
    else if (trip_clear_i) m_trip = 1'b0;
    exp_trip = m_trip;
  endtask

  // Single compare process: DUT against model every cycle.
  always @(negedge clk) begin
    if (chk_en) check("cycle_outputs", {PWM_hi_o, PWM_lo_o, tripped_o}, {exp_hi, exp_lo, exp_trip});
  end

  task automatic drive_counter();
    local_counter_i = cnt; current_period_i = cur_p; sync_phase_i = phase;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_update();
    #1;
    if (cnt == cur_p) begin
      cnt = '0;
      if (phase) begin phase = 1'b0; cur_p = next_p; end
      else phase = 1'b1;
    end else begin
      cnt = cnt + 16'd1;
    end
    drive_counter();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Tick until the next edge samples the boundary, then take that edge.
  task automatic wait_bnd(input string name);
    int k = 0;
    while (!(sync_phase_i && local_counter_i == current_period_i) && k < 8000) begin tick(); k++; end
    if (k >= 8000) timeout(name);
    tick();
  endtask

  task automatic wait_fall_start(input string name);
    int k = 0;
    while (!(sync_phase_i && local_counter_i == 16'd0) && k < 8000) begin tick(); k++; end
    if (k >= 8000) timeout(name);
  endtask

  task automatic window(output int hi0, output int lo0, output int hi1, output int lo1, output int gap);
    logic plo, phi;
    int fall_at = -1;
    hi0 = 0; lo0 = 0; hi1 = 0; lo1 = 0; gap = -1;
    plo = PWM_lo_o[1]; phi = PWM_hi_o[1];
    for (int k = 0; k < 3126; k++) begin
      tick();
      hi0 += int'(PWM_hi_o[0]); lo0 += int'(PWM_lo_o[0]);
      hi1 += int'(PWM_hi_o[1]); lo1 += int'(PWM_lo_o[1]);
      if (plo && !PWM_lo_o[1] && fall_at < 0) fall_at = k;
      if (!phi && PWM_hi_o[1] && fall_at >= 0 && gap < 0) gap = k - fall_at;
      plo = PWM_lo_o[1]; phi = PWM_hi_o[1];
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h0, l0, h1, l1, gap, k, ch;
    rst = 1'b1;
    duty_i = {16'd0, 16'd781, 16'd1563};
    override_i = '0; enable_i = 1'b1; trip_i = 1'b0; trip_clear_i = 1'b0;
    deadtime_i = 8'd10;
    cnt = '0; phase = 1'b0; cur_p = 16'd1562; next_p = 16'd1562;
    drive_counter();
    model_reset();
    #1 chk_en = 1'b1;
    run(4);
    check("reset_hi", PWM_hi_o, 0);
    check("reset_lo", PWM_lo_o, 0);
    check("reset_tripped", tripped_o, 0);
    rst = 1'b0;
    run(10);
    check("pre_bnd_hi", PWM_hi_o, 0);
    check("pre_bnd_lo", PWM_lo_o, 0);

    // steady waveform, duty above period on ch0, 781 on ch1, 0 on ch2
    wait_bnd("first_bnd");
    wait_fall_start("fall1");
    window(h0, l0, h1, l1, gap);
    check("ch0_full_hi", h0, 3126);
    check("ch0_full_lo", l0, 0);
    check("ch1_hi_width", h1, DT_ON ? 1551 : 1562);
    check("ch1_lo_width", l1, DT_ON ? 1553 : 1564);
    check("ch1_rise_after_fall", gap, DT_ON ? 11 : 0);
    check("ch2_lo_only", PWM_lo_o[2], 1);

    // duty change mid rising half takes effect only from the next period
    k = 0;
    while (!(!sync_phase_i && local_counter_i == 16'd700) && k < 8000) begin tick(); k++; end
    if (k >= 8000) timeout("mid_rise");
    duty_i[W +: W] = 16'd400;
    wait_bnd("bnd_duty");
    wait_fall_start("fall2");
    window(h0, l0, h1, l1, gap);
    check("ch1_new_hi_width", h1, DT_ON ? 789 : 800);
    check("ch1_new_lo_width", l1, DT_ON ? 2315 : 2326);

    // trip while ch0 is high
    trip_i = 1'b1;
    tick();
    trip_i = 1'b0;
    check("trip_hi", PWM_hi_o, 0);
    check("trip_lo", PWM_lo_o, 0);
    check("trip_latched", tripped_o, 1);
    run(5);
    trip_clear_i = 1'b1;
    tick();
    trip_clear_i = 1'b0;
    check("trip_cleared", tripped_o, 0);
    run(3);
    check("after_clear_hi", PWM_hi_o, 0);
    wait_bnd("bnd_trip");
    run(15);
    check("resume_hi0", PWM_hi_o[0], 1);

    // override 10 on ch2 (duty 0), then 01
    override_i[5:4] = 2'b10;
    k = 0;
    while (k < 50 && !(k > 0 && PWM_hi_o[2])) begin tick(); k++; end
    check("ovr_high_delay", k, DT_ON ? 12 : 1);
    override_i[5:4] = 2'b01;
    tick();
    check("ovr_low_hi", PWM_hi_o[2], 0);
    check("ovr_low_lo", PWM_lo_o[2], 0);
    override_i[5:4] = 2'b00;

    // asynchronous reset mid-period
    run(100);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_hi", PWM_hi_o, 0);
    check("async_rst_lo", PWM_lo_o, 0);
    run(3);
    rst = 1'b0;
    run(5);
    check("post_rst_hi", PWM_hi_o, 0);
    check("post_rst_lo", PWM_lo_o, 0);
    wait_bnd("bnd_rst");
    run(15);
    check("post_rst_resume", PWM_hi_o[0], 1);

    // randomized phase with short periods
    deadtime_i = 8'd2;
    next_p = 16'($urandom_range(2, 40));
    for (int i = 0; i < 6000; i++) begin
      trip_i = 1'b0; trip_clear_i = 1'b0;
      ch = $urandom_range(0, CH - 1);
      if ($urandom_range(0, 39) == 0) duty_i[ch*W +: W] = 16'($urandom_range(0, 44));
      if ($urandom_range(0, 99) == 0) override_i[2*ch +: 2] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) override_i = '0;
      if ($urandom_range(0, 299) == 0) trip_i = 1'b1;
      if ($urandom_range(0, 79) == 0) trip_clear_i = 1'b1;
      if ($urandom_range(0, 199) == 0) enable_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) deadtime_i = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 59) == 0) next_p = 16'($urandom_range(2, 40));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
